// File: rtl/issue_queue_wkup.sv
// issue_queue_wkup: collapsing issue queue with tag wakeup, late wakeup-data capture.
// Ports: in_* enqueue, wkup_* broadcast, issue_* select, count_o; opt. IQ_ENQ_BYPASS_EN.
package iq_wkup_pkg;
  typedef logic [63:0] word_t;
endpackage

module issue_queue_wkup
  import iq_wkup_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int REG_COUNT  = 2,
  parameter int WKUP_COUNT = 2,
  parameter int TAG_W      = 6,
  parameter int PAYLOAD_W  = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [REG_COUNT-1:0][TAG_W-1:0]       in_tag_i,
  input  logic [REG_COUNT-1:0]                  in_rdy_i,
  input  word_t [REG_COUNT-1:0]                 in_data_i,
  input  logic [PAYLOAD_W-1:0]                  in_payload_i,
  input  logic [WKUP_COUNT-1:0]                 wkup_valid_i,
  input  logic [WKUP_COUNT-1:0][TAG_W-1:0]      wkup_tag_i,
  input  word_t [WKUP_COUNT-1:0]                wkup_data_i,
  input  logic                                  issue_ready_i,
  output logic                                  issue_valid_o,
  output word_t [REG_COUNT-1:0]                 issue_data_o,
  output logic [REG_COUNT-1:0][WKUP_COUNT-1:0]  issue_wkup_hit_o,
  output logic [PAYLOAD_W-1:0]                  issue_payload_o,
  output logic [$clog2(DEPTH+1)-1:0]            count_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (WKUP_COUNT > 1) ? $clog2(WKUP_COUNT) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_HIT  = 2'd1;
  localparam logic [1:0] ST_RDY  = 2'd2;

  logic [CW-1:0]        count_q, n_count, wpos;
  logic [1:0]           st_q   [DEPTH][REG_COUNT];
  logic [1:0]           n_st   [DEPTH][REG_COUNT];
  logic [PW-1:0]        port_q [DEPTH][REG_COUNT];
  logic [PW-1:0]        n_port [DEPTH][REG_COUNT];
  logic [TAG_W-1:0]     tag_q  [DEPTH][REG_COUNT];
  logic [TAG_W-1:0]     n_tag  [DEPTH][REG_COUNT];
  word_t                data_q [DEPTH][REG_COUNT];
  word_t                n_data [DEPTH][REG_COUNT];
  logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
  logic [PAYLOAD_W-1:0] n_pay  [DEPTH];

  // Per-entry state after this edge's wakeup, before the collapse.
  // Slot DEPTH is a blank filler shifted into the top.
  logic [1:0]           u_st   [DEPTH+1][REG_COUNT];
  logic [PW-1:0]        u_port [DEPTH+1][REG_COUNT];
  logic [TAG_W-1:0]     u_tag  [DEPTH+1][REG_COUNT];
  word_t                u_data [DEPTH+1][REG_COUNT];
  logic [PAYLOAD_W-1:0] u_pay  [DEPTH+1];

  logic                 m_now  [DEPTH][REG_COUNT];
  logic [PW-1:0]        m_port [DEPTH][REG_COUNT];
  logic [REG_COUNT-1:0] e_now;
  logic [PW-1:0]        e_port [REG_COUNT];
  logic [DEPTH-1:0]     issuable;
  logic                 any;
  logic [IW-1:0]        sel;
  logic                 byp_ok, byp_take, q_issue, do_enq;

  // Lowest matching port wins when several broadcast the same tag.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        m_now[i][r]  = 1'b0;
        m_port[i][r] = '0;
        for (int w = WKUP_COUNT-1; w >= 0; w--) begin
          if (wkup_valid_i[w] && wkup_tag_i[w] == tag_q[i][r]) begin
            m_now[i][r]  = 1'b1;
            m_port[i][r] = PW'(w);
          end
        end
        if (st_q[i][r] != ST_WAIT) m_now[i][r] = 1'b0;
      end
    end
    for (int r = 0; r < REG_COUNT; r++) begin
      e_now[r]  = 1'b0;
      e_port[r] = '0;
      for (int w = WKUP_COUNT-1; w >= 0; w--) begin
        if (wkup_valid_i[w] && wkup_tag_i[w] == in_tag_i[r]) begin
          e_now[r]  = !in_rdy_i[r];
          e_port[r] = PW'(w);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      issuable[i] = CW'(i) < count_q;
      for (int r = 0; r < REG_COUNT; r++)
        if (st_q[i][r] == ST_WAIT && !m_now[i][r]) issuable[i] = 1'b0;
    end
    any = |issuable;
    sel = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (issuable[i]) sel = IW'(i);
  end

`ifdef IQ_ENQ_BYPASS_EN
  assign byp_ok = (count_q == '0) && in_valid_i && !flush
                && (&(in_rdy_i | e_now));
`else
  assign byp_ok = 1'b0;
`endif

  assign in_ready_o = count_q < CW'(DEPTH);
  assign count_o    = count_q;
  assign byp_take   = byp_ok && issue_ready_i;
  assign q_issue    = !flush && any && issue_ready_i;
  assign do_enq     = in_valid_i && in_ready_o && !flush && !byp_take;
  assign wpos       = count_q - CW'(q_issue);
  assign n_count    = count_q + CW'(do_enq) - CW'(q_issue);

  always_comb begin
    issue_valid_o    = 1'b0;
    issue_data_o     = '0;
    issue_wkup_hit_o = '0;
    issue_payload_o  = '0;
    if (!flush && any) begin
      issue_valid_o   = 1'b1;
      issue_payload_o = pay_q[sel];
      for (int r = 0; r < REG_COUNT; r++) begin
        unique case (1'b1)
          st_q[sel][r] == ST_RDY:
            issue_data_o[r] = data_q[sel][r];
          st_q[sel][r] == ST_HIT:
            issue_data_o[r] = wkup_data_i[port_q[sel][r]];
          default:
            if (m_now[sel][r])
              issue_wkup_hit_o[r][m_port[sel][r]] = 1'b1;
        endcase
      end
    end else if (byp_ok) begin
      issue_valid_o   = 1'b1;
      issue_payload_o = in_payload_i;
      for (int r = 0; r < REG_COUNT; r++) begin
        if (in_rdy_i[r])
          issue_data_o[r] = in_data_i[r];
        else if (e_now[r])
          issue_wkup_hit_o[r][e_port[r]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i <= DEPTH; i++) begin
      u_pay[i] = '0;
      for (int r = 0; r < REG_COUNT; r++) begin
        u_st[i][r]   = ST_WAIT;
        u_port[i][r] = '0;
        u_tag[i][r]  = '0;
        u_data[i][r] = '0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      u_pay[i] = pay_q[i];
      for (int r = 0; r < REG_COUNT; r++) begin
        u_st[i][r]   = st_q[i][r];
        u_port[i][r] = port_q[i][r];
        u_tag[i][r]  = tag_q[i][r];
        u_data[i][r] = data_q[i][r];
        if (st_q[i][r] == ST_HIT) begin
          u_st[i][r]   = ST_RDY;
          u_data[i][r] = wkup_data_i[port_q[i][r]];
        end else if (m_now[i][r]) begin
          u_st[i][r]   = ST_HIT;
          u_port[i][r] = m_port[i][r];
        end
      end
    end
  end

  // Collapse above the issued slot, then append at the new tail.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      if (q_issue && IW'(j) >= sel) begin
        n_pay[j] = u_pay[j+1];
        for (int r = 0; r < REG_COUNT; r++) begin
          n_st[j][r]   = u_st[j+1][r];
          n_port[j][r] = u_port[j+1][r];
          n_tag[j][r]  = u_tag[j+1][r];
          n_data[j][r] = u_data[j+1][r];
        end
      end else begin
        n_pay[j] = u_pay[j];
        for (int r = 0; r < REG_COUNT; r++) begin
          n_st[j][r]   = u_st[j][r];
          n_port[j][r] = u_port[j][r];
          n_tag[j][r]  = u_tag[j][r];
          n_data[j][r] = u_data[j][r];
        end
      end
      if (do_enq && CW'(j) == wpos) begin
        n_pay[j] = in_payload_i;
        for (int r = 0; r < REG_COUNT; r++) begin
          n_tag[j][r]  = in_tag_i[r];
          n_data[j][r] = in_data_i[r];
          n_port[j][r] = e_port[r];
          n_st[j][r]   = in_rdy_i[r] ? ST_RDY :
                         e_now[r]    ? ST_HIT : ST_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        for (int r = 0; r < REG_COUNT; r++)
          st_q[i][r] <= ST_WAIT;
    end else if (flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        for (int r = 0; r < REG_COUNT; r++)
          st_q[i][r] <= ST_WAIT;
    end else begin
      count_q <= n_count;
      for (int i = 0; i < DEPTH; i++)
        for (int r = 0; r < REG_COUNT; r++)
          st_q[i][r] <= n_st[i][r];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      pay_q[i] <= n_pay[i];
      for (int r = 0; r < REG_COUNT; r++) begin
        port_q[i][r] <= n_port[i][r];
        tag_q[i][r]  <= n_tag[i][r];
        data_q[i][r] <= n_data[i][r];
      end
    end
  end

endmodule
